mod_ring_tracker: RTL



---
 rtl/mod_ring_tracker.sv | 108 ++++++++++
 1 files changed

// File: rtl/mod_ring_tracker.sv
// mod_ring_tracker: modulo-DEPTH ring manager for fetch-stage slot allocation.
// Each cycle it tracks a head (retire) pointer, a tail (allocate) pointer and
// an occupancy count, and accepts allocate and retire bursts of variable size.
//
// Handshake: an allocate fires on a clock edge where alloc_valid && alloc_ready.
// alloc_ready depends only on alloc_count and the registered occupancy, so the
// requester may look at alloc_ready before it decides to raise alloc_valid.
// A retire has no ready signal. It fires when retire_count <= occupancy;
// otherwise it is dropped and err_underflow is latched.
module mod_ring_tracker #(
  parameter int DEPTH      = 40,
  parameter int PTR_WIDTH  = 6,
  parameter int CNT_WIDTH  = 6,
  parameter int STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic [STEP_WIDTH-1:0] alloc_count,
  output logic                  alloc_ready,
  output logic [PTR_WIDTH-1:0]  alloc_base,
  input  logic                  retire_valid,
  input  logic [STEP_WIDTH-1:0] retire_count,
  output logic [PTR_WIDTH-1:0]  head_ptr,
  output logic [PTR_WIDTH-1:0]  tail_ptr,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  err_underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_P = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0] occ_q, occ_d;
  logic                 err_q, err_d;

  logic [CNT_WIDTH:0]   alloc_sum;
  logic                 retire_ok;
  logic                 alloc_fire;
  logic                 retire_fire;
  logic [CNT_WIDTH-1:0] alloc_amt;
  logic [CNT_WIDTH-1:0] retire_amt;

  // Pointer advance with a single conditional wrap. Because a step never
  // exceeds DEPTH, one subtraction always brings the sum back into range.
  function automatic logic [PTR_WIDTH-1:0] mod_add(
    input logic [PTR_WIDTH-1:0]  p,
    input logic [STEP_WIDTH-1:0] n
  );
    logic [PTR_WIDTH:0] s;
    s = {1'b0, p} + (PTR_WIDTH+1)'(n);
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_WIDTH-1:0];
  endfunction

  // Acceptance decode from registered occupancy, plus next-state computation.
  always_comb begin
    alloc_sum   = {1'b0, occ_q} + (CNT_WIDTH+1)'(alloc_count);
    alloc_ready = (alloc_sum <= DEPTH_C);
    retire_ok   = (CNT_WIDTH'(retire_count) <= occ_q);
    alloc_fire  = alloc_valid && alloc_ready;
    retire_fire = retire_valid && retire_ok;
    alloc_amt   = alloc_fire  ? CNT_WIDTH'(alloc_count)  : '0;
    retire_amt  = retire_fire ? CNT_WIDTH'(retire_count) : '0;

    head_d = retire_fire ? mod_add(head_q, retire_count) : head_q;
    tail_d = alloc_fire  ? mod_add(tail_q, alloc_count)  : tail_q;
    // The add is done first, so the intermediate value never goes negative.
    occ_d  = occ_q + alloc_amt - retire_amt;
    err_d  = err_q || (retire_valid && !retire_ok);
  end

  // State registers. Flush takes priority over any same-cycle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  // Status outputs are decoded from registers only.
  always_comb begin
    head_ptr      = head_q;
    tail_ptr      = tail_q;
    alloc_base    = tail_q;
    occupancy     = occ_q;
    full          = (occ_q == DEPTH_C[CNT_WIDTH-1:0]);
    empty         = (occ_q == '0);
    err_underflow = err_q;
  end

endmodule
